load_store_unit: RTL

Core-side initiator for the data memory port. Accepts one RV32I load/store request at a time from the execute stage and decodes funct3 into a word-aligned address, byte write mask and lane-replicated write data. Drives the data memory's read/write/busy protocol, then returns sign- or zero-extended load data, or a fault flag for misaligned or illegal accesses. Sits between the core pipeline and the data memory.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory bus of the load/store unit
//   slave  : load/store unit side (takes requests, drives the memory strobes)
//   master : environment side (core pipeline plus data memory)
interface load_store_unit_if #(parameter int width_p = 32);
    logic               req_valid_i;
    logic               req_ready_o;
    logic               req_store_i;
    logic [2:0]         req_funct3_i;
    logic [width_p-1:0] req_addr_i;
    logic [width_p-1:0] req_wdata_i;
    logic               resp_valid_o;
    logic [width_p-1:0] resp_rdata_o;
    logic               resp_fault_o;
    logic [width_p-1:0] mem_addr_o;
    logic               mem_read_enable_o;
    logic               mem_write_enable_o;
    logic [width_p-1:0] mem_write_data_o;
    logic [3:0]         mem_write_mask_o;
    logic [width_p-1:0] mem_read_data_i;
    logic               mem_busy_i;
    modport slave (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_read_data_i, mem_busy_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
        output mem_addr_o, mem_read_enable_o, mem_write_enable_o, mem_write_data_o, mem_write_mask_o
    );
    modport master (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_read_data_i, mem_busy_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
        input  mem_addr_o, mem_read_enable_o, mem_write_enable_o, mem_write_data_o, mem_write_mask_o
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32I load/store initiator for the data memory port
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : request/response handshake and data-memory read/write/busy bus (slave side)
module load_store_unit #(parameter int width_p = 32) (
    input logic             clk_i,
    input logic             reset_i,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, LOAD_DATA, STORE_WAIT, RESP} state_e;
    state_e state_q, state_d;
    logic               store_q, store_d, fault_q, fault_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         lane_q, lane_d;
    logic [3:0]         mask_q, mask_d;
    logic [width_p-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic               accept, req_fault;
    logic [2:0]         f3;
    logic [1:0]         a;
    logic [width_p-1:0] shifted, ld_ext;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    assign f3 = bus.req_funct3_i;
    assign a = bus.req_addr_i[1:0];
    assign accept = state_q == IDLE && bus.req_valid_i;
    assign req_fault = f3 == 3'd3 || f3[2:1] == 2'b11 || (bus.req_store_i && f3[2]) ||
                       (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a != 2'b00);
    assign shifted = bus.mem_read_data_i >> {lane_q, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = lane_q[1] ? bus.mem_read_data_i[31:16] : bus.mem_read_data_i[15:0];
    assign ld_ext = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte} :
                    funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & ld_half[15]}}, ld_half} :
                    bus.mem_read_data_i;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            lane_q   <= 2'd0;
            mask_q   <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = accept ? (req_fault ? RESP : ISSUE) : IDLE;
            ISSUE:      state_d = !store_q ? LOAD_DATA : bus.mem_busy_i ? STORE_WAIT : RESP;
            LOAD_DATA:  state_d = RESP;
            STORE_WAIT: state_d = bus.mem_busy_i ? STORE_WAIT : RESP;
            default:    state_d = IDLE;
        endcase
    end
    // Request fields are captured on accept only, so the memory sees a stable
    // address/mask/data through any read-modify-write busy period.
    always_comb begin
        store_d  = store_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        if (accept) begin
            store_d  = bus.req_store_i;
            funct3_d = f3;
            lane_d   = a;
            addr_d   = {bus.req_addr_i[width_p-1:2], 2'b00};
            mask_d   = f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdata_d  = f3[1:0] == 2'b00 ? {4{bus.req_wdata_i[7:0]}} :
                       f3[1:0] == 2'b01 ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
        end
        // Response fields move only on entry to RESP so they hold between responses.
        if (state_d == RESP && state_q != RESP) begin
            rdata_d = state_q == LOAD_DATA ? ld_ext : '0;
            fault_d = state_q == IDLE;
        end
    end
    always_comb begin
        bus.req_ready_o        = state_q == IDLE;
        bus.mem_read_enable_o  = state_q == ISSUE && !store_q;
        bus.mem_write_enable_o = state_q == ISSUE && store_q;
        bus.resp_valid_o       = state_q == RESP;
    end
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_write_data_o = wdata_q;
    assign bus.mem_write_mask_o = mask_q;
    assign bus.resp_rdata_o     = rdata_q;
    assign bus.resp_fault_o     = fault_q;
endmodule
